// File: rtl/enc4x2_evt.sv
// Event encoder: detects falling edges on four active-low select lines, queues one
// pending event per line and presents the highest-priority index on a valid/ready port.
module enc4x2_evt #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] y_n,
  input  logic       ready,
  output logic       a,
  output logic       b,
  output logic       valid,
  output logic       drop
);

  logic [3:0] r_sync [SYNC_STAGES];
  logic [3:0] r_hist;
  logic [3:0] r_pend;
  logic [1:0] r_code;
  logic       r_valid;
  logic       r_drop;

  logic [3:0] w_fall;
  logic [3:0] w_cand;
  logic [3:0] w_ld;
  logic [3:0] w_pend_nxt;
  logic [1:0] w_idx;
  logic       w_slot;
  logic       w_load;
  logic       w_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 4'hF;
      r_hist <= 4'hF;
    end else begin
      r_sync[0] <= y_n;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_fall = r_hist & ~r_sync[SYNC_STAGES-1] & {4{en}};
  assign w_cand = r_pend | w_fall;
  assign w_slot = ~r_valid | ready;
  assign w_load = w_slot & (|w_cand);

  always_comb begin
    w_idx = 2'd0;
    if (w_cand[3])      w_idx = 2'd3;
    else if (w_cand[2]) w_idx = 2'd2;
    else if (w_cand[1]) w_idx = 2'd1;
  end

  assign w_ld = w_load ? (4'b0001 << w_idx) : 4'b0000;

  // A loaded line keeps its pending bit only when a fresh edge arrives in the same cycle.
  assign w_pend_nxt = (w_ld & r_pend & w_fall) | (~w_ld & (r_pend | w_fall));
  assign w_drop     = |(w_fall & r_pend & ~w_ld);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend  <= 4'b0000;
      r_code  <= 2'd0;
      r_valid <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_drop <= w_drop;
      if (w_slot) begin
        r_valid <= w_load;
        if (w_load) r_code <= w_idx;
      end
    end
  end

  assign a     = r_code[1];
  assign b     = r_code[0];
  assign valid = r_valid;
  assign drop  = r_drop;

endmodule

// File: tb/tb_enc4x2_evt.sv
// Bench for enc4x2_evt: directed scenarios plus randomized traffic, all checked
// cycle by cycle against an event-queue model built from the encoder's rules.
module tb_enc4x2_evt;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] y_n;
  logic       ready;
  logic       a, b, valid, drop;

  int n_cmp = 0;
  int n_err = 0;

  enc4x2_evt #(.SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .en(en), .y_n(y_n), .ready(ready),
    .a(a), .b(b), .valid(valid), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: y_n samples of past edges, pending set, presented event.
  logic [3:0] q [0:S];
  logic [3:0] m_pend = 4'b0;
  logic [1:0] m_code = 2'd0;
  logic       m_valid = 1'b0;
  logic       m_drop = 1'b0;
  bit         started = 1'b0;

  always @(posedge clk) begin
    logic [3:0] fall, cand, newp;
    int         idx;
    bit         dn;
    started = 1'b1;
    if (rst) begin
      m_pend = 4'b0; m_code = 2'd0; m_valid = 1'b0; m_drop = 1'b0;
      for (int i = 0; i <= S; i++) q[i] = 4'hF;
    end else begin
      // A line fires when its synchronized value was high one sample earlier and is low now.
      fall = q[S] & ~q[S-1] & {4{en}};
      cand = m_pend | fall;
      idx  = -1;
      if (!m_valid || ready) begin
        for (int i = 3; i >= 0; i--)
          if (idx < 0 && cand[i]) idx = i;
        if (idx >= 0) begin
          m_code  = 2'(idx);
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      dn = 1'b0;
      newp = m_pend;
      for (int i = 0; i < 4; i++) begin
        if (i == idx) newp[i] = m_pend[i] && fall[i];
        else begin
          if (fall[i] && m_pend[i]) dn = 1'b1;
          newp[i] = m_pend[i] || fall[i];
        end
      end
      m_pend = newp;
      m_drop = dn;
      for (int i = S; i >= 1; i--) q[i] = q[i-1];
      q[0] = y_n;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("valid", valid, m_valid);
      chk("drop", drop, m_drop);
      if (m_valid) chk("code", {a, b}, m_code);
    end
  end

  // Handshake log and drop counter for the directed scenarios.
  logic [1:0] hs_log [$];
  int         drop_cnt = 0;

  always @(posedge clk)
    if (!rst && valid && ready) hs_log.push_back({a, b});

  always @(negedge clk)
    if (drop) drop_cnt++;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [3:0] v, input int lo, input int hi);
    y_n = v; cyc(lo);
    y_n = 4'hF; cyc(hi);
  endtask

  initial begin
    int nv, d0, hold;
    rst = 1'b1; en = 1'b1; y_n = 4'hF; ready = 1'b0;
    cyc(3);
    chk("rst_a", a, 1'b0);
    chk("rst_b", b, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_drop", drop, 1'b0);

    // First event after release: line 2 low for one cycle, code 10 two edges later.
    rst = 1'b0; y_n = 4'b1011;
    cyc(1); y_n = 4'hF;
    cyc(1);
    chk("first_evt_early_valid", valid, 1'b0);
    cyc(1);
    chk("first_evt_valid", valid, 1'b1);
    chk("first_evt_code", {a, b}, 2'b10);
    ready = 1'b1; cyc(3); ready = 1'b0;

    // Simultaneous falls on lines 3 and 0: 3 wins, 0 follows.
    y_n = 4'b0110; cyc(4); y_n = 4'hF;
    chk("prio_valid", valid, 1'b1);
    chk("prio_first", {a, b}, 2'b11);
    ready = 1'b1; cyc(1);
    chk("prio_second_valid", valid, 1'b1);
    chk("prio_second", {a, b}, 2'b00);
    cyc(1);
    chk("prio_empty", valid, 1'b0);

    // Backpressure: three pulses on line 1 give one presented, one pending, one drop.
    ready = 1'b0; d0 = drop_cnt;
    pulse(4'b1101, 2, 2);
    chk("bp_first_valid", valid, 1'b1);
    chk("bp_first_code", {a, b}, 2'b01);
    pulse(4'b1101, 2, 2);
    pulse(4'b1101, 2, 4);
    chk("bp_drop_pulses", drop_cnt - d0, 1);
    hs_log.delete();
    ready = 1'b1; cyc(4);
    chk("bp_handshakes", hs_log.size(), 2);
    if (hs_log.size() == 2) begin
      chk("bp_hs0", hs_log[0], 2'b01);
      chk("bp_hs1", hs_log[1], 2'b01);
    end

    // Enable gating: a line-2 edge is ignored, but queued events still drain.
    ready = 1'b0;
    pulse(4'b0111, 2, 2);
    pulse(4'b1101, 2, 3);
    en = 1'b0;
    pulse(4'b1011, 2, 1);
    chk("en_hold_valid", valid, 1'b1);
    chk("en_hold_code", {a, b}, 2'b11);
    hs_log.delete();
    ready = 1'b1; cyc(5);
    en = 1'b1; cyc(3);
    chk("en_handshakes", hs_log.size(), 2);
    if (hs_log.size() == 2) begin
      chk("en_hs0", hs_log[0], 2'b11);
      chk("en_hs1", hs_log[1], 2'b01);
    end
    chk("en_empty", valid, 1'b0);

    // Held level on line 0 yields exactly one event.
    nv = 0; y_n = 4'b1110;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (valid && {a, b} == 2'b00) nv++;
    end
    y_n = 4'hF; cyc(4);
    chk("held_one_event", nv, 1);

    // Reset while presenting with a pending event discards both.
    ready = 1'b0;
    pulse(4'b1110, 2, 2);
    pulse(4'b1011, 2, 3);
    chk("midrst_pre_valid", valid, 1'b1);
    chk("midrst_pre_code", {a, b}, 2'b00);
    rst = 1'b1; cyc(1);
    chk("midrst_valid", valid, 1'b0);
    chk("midrst_code", {a, b}, 2'b00);
    rst = 1'b0; ready = 1'b1; hs_log.delete(); cyc(6);
    chk("midrst_no_event", hs_log.size(), 0);
    chk("midrst_idle", valid, 1'b0);

    // Randomized traffic against the model.
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        y_n  = 4'($urandom);
        hold = $urandom_range(1, 5);
      end
      hold--;
      en    = ($urandom_range(0, 9) != 0);
      ready = ($urandom_range(0, 2) != 0);
      rst   = ($urandom_range(0, 199) == 0);
      cyc(1);
    end
    rst = 1'b0; y_n = 4'hF; ready = 1'b1; cyc(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
